// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared constants, FSM states and magnitude helper for the FAS frame scheduler
package fas_pkg;

    localparam int N_PT   = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int MAG_W  = 33;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SCAN,
        FINAL,
        HALT
    } fsm_state_e;

    // Squares are non-negative and below 2^31, so the 33-bit sum never wraps.
    function automatic logic [MAG_W-1:0] mag_sq(input logic signed [DATA_W-1:0] re,
                                               input logic signed [DATA_W-1:0] im);
        logic signed [2*DATA_W-1:0] re_x;
        logic signed [2*DATA_W-1:0] im_x;
        re_x = (2*DATA_W)'(re);
        im_x = (2*DATA_W)'(im);
        return {1'b0, re_x * re_x} + {1'b0, im_x * im_x};
    endfunction

endpackage

// File: rtl/fas_peak_search.sv
// rtl/fas_peak_search.sv - registered |X|^2 per bin and strict-greater peak tracker
module fas_peak_search
    import fas_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     valid,
    input  logic [ADDR_W-1:0]        idx,
    input  logic signed [DATA_W-1:0] re,
    input  logic signed [DATA_W-1:0] im,
    output logic [ADDR_W-1:0]        peak_idx
);

    logic [MAG_W-1:0]  mag_q, mag_d;
    logic [ADDR_W-1:0] mag_idx_q, mag_idx_d;
    logic              mag_vld_q, mag_vld_d;
    logic [MAG_W-1:0]  max_q, max_d;
    logic [ADDR_W-1:0] best_q, best_d;
    logic              take;

    always_comb begin
        mag_d     = mag_sq(re, im);
        mag_idx_d = idx;
        mag_vld_d = valid & ~clear;
        take      = mag_vld_q && (mag_q > max_q);
        max_d     = max_q;
        best_d    = best_q;
        if (clear) begin
            max_d  = '0;
            best_d = '0;
        end else if (take) begin
            max_d  = mag_q;
            best_d = mag_idx_q;
        end
        // The compare of the bin in the pipe is visible in the same cycle it happens.
        peak_idx = take ? mag_idx_q : best_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q     <= '0;
            mag_idx_q <= '0;
            mag_vld_q <= 1'b0;
            max_q     <= '0;
            best_q    <= '0;
        end else begin
            mag_q     <= mag_d;
            mag_idx_q <= mag_idx_d;
            mag_vld_q <= mag_vld_d;
            max_q     <= max_d;
            best_q    <= best_d;
        end
    end

endmodule

// File: rtl/fas_frame_sched.sv
// rtl/fas_frame_sched.sv - ping-pong frame packer, FFT launcher and peak-bin analysis controller
module fas_frame_sched
    import fas_pkg::*;
#(
    parameter int FRAMES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fir_valid,
    input  logic signed [DATA_W-1:0] fir_d,
    output logic                     buf_we,
    output logic                     buf_bank,
    output logic [ADDR_W-1:0]        buf_addr,
    output logic [DATA_W-1:0]        buf_wdata,
    output logic                     fft_start,
    output logic                     fft_bank,
    input  logic                     fft_done,
    output logic [ADDR_W-1:0]        bin_sel,
    input  logic signed [DATA_W-1:0] bin_re,
    input  logic signed [DATA_W-1:0] bin_im,
    output logic                     fft_valid,
    output logic [ADDR_W-1:0]        freq,
    output logic                     done,
    output logic                     ovr_err
);

    localparam int FCW = $clog2(FRAMES + 1);

    fsm_state_e        state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        pending_q, pending_d;
    logic              rd_bank_q, rd_bank_d;
    logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              buf_we_q, buf_we_d;
    logic              buf_bank_q, buf_bank_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
    logic              fft_bank_q, fft_bank_d;
    logic              fft_valid_q, fft_valid_d;
    logic [ADDR_W-1:0] freq_q, freq_d;
    logic              done_q, done_d;
    logic              ovr_err_q, ovr_err_d;
    logic              scan_clear;
    logic              scan_valid;
    logic [ADDR_W-1:0] peak_idx;

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        pending_d   = pending_q;
        rd_bank_d   = rd_bank_q;
        frame_cnt_d = frame_cnt_q;
        cnt_d       = cnt_q;
        buf_we_d    = 1'b0;
        buf_bank_d  = buf_bank_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        fft_bank_d  = fft_bank_q;
        fft_valid_d = 1'b0;
        freq_d      = freq_q;
        done_d      = done_q;
        ovr_err_d   = ovr_err_q;
        scan_clear  = 1'b0;

        // A sample aimed at a bank the FFT has not released is dropped.
        if (fir_valid) begin
            if (pending_q[wr_bank_q]) begin
                ovr_err_d = 1'b1;
            end else begin
                buf_we_d    = 1'b1;
                buf_bank_d  = wr_bank_q;
                buf_addr_d  = wr_addr_q;
                buf_wdata_d = fir_d;
                wr_addr_d   = wr_addr_q + ADDR_W'(1);
                if (wr_addr_q == ADDR_W'(N_PT - 1)) begin
                    pending_d[wr_bank_q] = 1'b1;
                    wr_bank_d            = ~wr_bank_q;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (pending_q[rd_bank_q]) begin
                    fft_bank_d = rd_bank_q;
                    state_d    = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (fft_done) begin
                    pending_d[rd_bank_q] = 1'b0;
                    rd_bank_d            = ~rd_bank_q;
                    fft_valid_d          = 1'b1;
                    cnt_d                = '0;
                    scan_clear           = 1'b1;
                    state_d              = SCAN;
                end
            end
            SCAN: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(N_PT - 1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                freq_d      = peak_idx;
                frame_cnt_d = frame_cnt_q + FCW'(1);
                if (frame_cnt_q == FCW'(FRAMES - 1)) begin
                    done_d  = 1'b1;
                    state_d = HALT;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            pending_q   <= '0;
            rd_bank_q   <= 1'b0;
            frame_cnt_q <= '0;
            cnt_q       <= '0;
            buf_we_q    <= 1'b0;
            buf_bank_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            fft_bank_q  <= 1'b0;
            fft_valid_q <= 1'b0;
            freq_q      <= '0;
            done_q      <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            pending_q   <= pending_d;
            rd_bank_q   <= rd_bank_d;
            frame_cnt_q <= frame_cnt_d;
            cnt_q       <= cnt_d;
            buf_we_q    <= buf_we_d;
            buf_bank_q  <= buf_bank_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            fft_bank_q  <= fft_bank_d;
            fft_valid_q <= fft_valid_d;
            freq_q      <= freq_d;
            done_q      <= done_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    assign scan_valid = (state_q == SCAN);

    fas_peak_search u_peak (
        .clk      (clk),
        .rst      (rst),
        .clear    (scan_clear),
        .valid    (scan_valid),
        .idx      (cnt_q),
        .re       (bin_re),
        .im       (bin_im),
        .peak_idx (peak_idx)
    );

    assign buf_we    = buf_we_q;
    assign buf_bank  = buf_bank_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdata = buf_wdata_q;
    assign fft_start = (state_q == START);
    assign fft_bank  = fft_bank_q;
    assign bin_sel   = scan_valid ? cnt_q : '0;
    assign fft_valid = fft_valid_q;
    assign freq      = freq_q;
    assign done      = done_q;
    assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_fas_frame_sched.sv
// tb/tb_fas_frame_sched.sv - scoreboard bench for fas_frame_sched with an FFT core model
module tb_fas_frame_sched;
    import fas_pkg::*;

    localparam int FRAMES = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fir_valid = 1'b0;
    logic [15:0]        fir_d = '0;
    logic               buf_we, buf_bank, fft_start, fft_bank, fft_valid, done, ovr_err;
    logic [3:0]         buf_addr, bin_sel, freq;
    logic [15:0]        buf_wdata;
    logic               fft_done = 1'b0;
    logic signed [15:0] bin_re, bin_im;
    logic signed [15:0] f_re [16];
    logic signed [15:0] f_im [16];

    fas_frame_sched #(.FRAMES(FRAMES)) dut (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .buf_we(buf_we), .buf_bank(buf_bank), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .fft_start(fft_start), .fft_bank(fft_bank), .fft_done(fft_done),
        .bin_sel(bin_sel), .bin_re(bin_re), .bin_im(bin_im),
        .fft_valid(fft_valid), .freq(freq), .done(done), .ovr_err(ovr_err)
    );

    assign bin_re = f_re[bin_sel];
    assign bin_im = f_im[bin_sel];

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bank;
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  wq[$];
    bit   sq[$];
    int   fq[$];
    wr_t  me;
    wr_t  we_exp;
    bit   m_bank = 0;
    int   m_cnt = 0;
    bit [1:0] m_pend = 2'b00;
    bit   m_rel = 0;
    bit   m_ovr = 0;
    int   m_frames = 0;
    int   lat_set = 4;
    int   lat_cnt = 0;
    int   starts = 0;
    int   pat_mode = 0;
    int   valid_cnt = 0;
    bit   done_prev = 0;
    int   epoch = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    function automatic logic signed [15:0] rnd_val();
        logic signed [15:0] v;
        v = 16'($urandom_range(0, 4) * 192);
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // Loads one frame of FFT results and queues the peak bin the spec rules imply.
    task automatic load_bins();
        longint best;
        longint m;
        int     bi;
        int     kind;
        kind = $urandom_range(0, 7);
        for (int k = 0; k < 16; k++) begin
            case (pat_mode)
                1: begin f_re[k] = '0; f_im[k] = '0; end
                2: begin
                    f_re[k] = 16'($signed($urandom_range(0, 512)) - 256);
                    f_im[k] = 16'($signed($urandom_range(0, 512)) - 256);
                end
                default: begin
                    if (kind == 0) begin f_re[k] = '0; f_im[k] = '0; end
                    else if (kind == 1) begin f_re[k] = 16'($urandom); f_im[k] = 16'($urandom); end
                    else begin f_re[k] = rnd_val(); f_im[k] = rnd_val(); end
                end
            endcase
        end
        if (pat_mode == 1) begin
            f_re[5] = 16'sh0300;
            f_im[5] = -16'sh0400;
        end else if (pat_mode == 2) begin
            f_re[3] = 16'sh0500; f_im[3] = '0;
            f_re[9] = '0;        f_im[9] = -16'sh0500;
        end
        best = 0;
        bi = 0;
        for (int k = 0; k < 16; k++) begin
            m = longint'(f_re[k]) * longint'(f_re[k]) + longint'(f_im[k]) * longint'(f_im[k]);
            if (m > best) begin best = m; bi = k; end
        end
        fq.push_back(bi);
    endtask

    // Reference of the write side: samples fill banks in order, frames release in order.
    always @(posedge clk) begin
        if (!rst) begin
            if (fir_valid) begin
                if (m_pend[m_bank]) begin
                    m_ovr = 1'b1;
                end else begin
                    me.bank = m_bank;
                    me.addr = 4'(m_cnt);
                    me.data = fir_d;
                    wq.push_back(me);
                    m_cnt++;
                    if (m_cnt == N_PT) begin
                        m_cnt = 0;
                        m_pend[m_bank] = 1'b1;
                        if (m_frames < FRAMES) sq.push_back(m_bank);
                        m_frames++;
                        m_bank = ~m_bank;
                    end
                end
            end
            if (fft_done) begin
                m_pend[m_rel] = 1'b0;
                m_rel = ~m_rel;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && fft_start) begin
            starts++;
            lat_cnt = (lat_set > 0) ? lat_set : $urandom_range(1, 6);
        end
    end

    always @(posedge clk) begin
        #1;
        fft_done = 1'b0;
        if (rst) begin
            lat_cnt = 0;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                load_bins();
                fft_done = 1'b1;
            end
        end
    end

    task automatic freq_check(input int ef, input int k, input int ep);
        repeat (17) @(negedge clk);
        if (ep == epoch) begin
            chk("freq", freq, ef);
            chk("done_flag", done, (k >= FRAMES) ? 1 : 0);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (buf_we) begin
                    if (wq.size() == 0) fail_evt("write_unexpected");
                    else begin
                        we_exp = wq.pop_front();
                        chk("write", {buf_bank, buf_addr, buf_wdata}, we_exp);
                    end
                end
                if (fft_start) begin
                    if (sq.size() == 0) fail_evt("fft_start_unexpected");
                    else chk("fft_bank", fft_bank, sq.pop_front());
                end
                if (fft_valid || done_prev) chk("fft_valid_timing", fft_valid, done_prev);
                if (fft_valid) begin
                    valid_cnt++;
                    if (fq.size() == 0) fail_evt("fft_valid_unexpected");
                    else begin
                        automatic int ef = fq.pop_front();
                        automatic int kk = valid_cnt;
                        automatic int ee = epoch;
                        fork
                            freq_check(ef, kk, ee);
                        join_none
                    end
                end
                done_prev = fft_done;
            end
        end
    end

    task automatic step(input bit v, input logic [15:0] d);
        @(posedge clk);
        #1;
        fir_valid = v;
        fir_d = d;
    endtask

    task automatic wait_valid(input int k);
        int n;
        n = 0;
        while (valid_cnt < k && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (valid_cnt < k) fail_evt("timeout_fft_valid");
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        epoch++;
        #1;
        chk("reset_outputs", {buf_we, buf_bank, buf_addr, buf_wdata, fft_start, fft_bank,
                              bin_sel, fft_valid, freq, done, ovr_err}, 0);
        wq.delete(); sq.delete(); fq.delete();
        m_bank = 0; m_cnt = 0; m_pend = 2'b00; m_rel = 0; m_ovr = 0; m_frames = 0;
        valid_cnt = 0; lat_cnt = 0; starts = 0;
        fft_done = 1'b0;
        fir_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : main
        int n;
        for (int k = 0; k < 16; k++) begin f_re[k] = '0; f_im[k] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {buf_we, buf_bank, buf_addr, buf_wdata, fft_start, fft_bank,
                            bin_sel, fft_valid, freq, done, ovr_err}, 0);
        rst = 1'b0;

        pat_mode = 1;
        lat_set = 4;
        for (int i = 0; i < 16; i++) step(1'b1, 16'h0100 + 16'(i));
        step(1'b0, 16'h0000);
        @(negedge clk);
        chk("last_write_lands", {buf_we, buf_addr}, 5'h1F);
        chk("no_start_with_last_write", fft_start, 0);
        @(negedge clk);
        chk("start_after_frame", fft_start, 1);
        chk("start_bank0", fft_bank, 0);
        wait_valid(1);
        repeat (20) @(posedge clk);
        chk("freq_bin5", freq, 5);

        pat_mode = 2;
        for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom));
        step(1'b0, 16'h0000);
        wait_valid(2);
        repeat (20) @(posedge clk);
        chk("freq_tie_low", freq, 3);

        pat_mode = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom));
        step(1'b0, 16'h0000);
        wait_valid(3);
        repeat (5) @(posedge clk);
        apply_reset();

        lat_set = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom));
        n = 0;
        while (starts < 40 && n < 4000) begin
            step($urandom_range(0, 4) < 2, 16'($urandom));
            n++;
        end
        if (starts < 40) fail_evt("timeout_random_phase");
        chk("ovr_before_stall", ovr_err, m_ovr);

        lat_set = 40;
        n = 0;
        while (starts < 41 && n < 300) begin
            step(1'b1, 16'($urandom));
            n++;
        end
        lat_set = 0;
        repeat (60) step(1'b1, 16'($urandom));
        chk("ovr_after_stall", ovr_err, 1);

        n = 0;
        while (!done && n < 6000) begin
            step($urandom_range(0, 4) < 2, 16'($urandom));
            n++;
        end
        chk("done_reached", done, 1);
        repeat (40) step($urandom_range(0, 1) == 1, 16'($urandom));
        chk("starts_total", starts, FRAMES);
        repeat (20) step(1'b0, 16'h0000);
        chk("write_queue_drained", wq.size(), 0);
        chk("freq_queue_drained", fq.size(), 0);
        chk("ovr_end", ovr_err, m_ovr);
        chk("done_held", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
